// File: rtl/demux_1x4_rr_sched_pkg.sv
// Shared types for the credit-based round-robin demux scheduler.
package demux_sched_pkg;

  localparam int NUM_CH = 4;

  typedef logic [1:0] ch_idx_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    SEND = 2'd2
  } sched_state_t;

endpackage

// File: rtl/demux_1x4_rr_sched_rr_arb4.sv
// Combinational 4-way round-robin picker: zero latency, starts the search one past last_grant.
module rr_arb4
  import demux_sched_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  ch_idx_t           last_grant,
  output logic              grant_valid,
  output ch_idx_t           grant_idx
);

  ch_idx_t cand;

  // Walk offsets from farthest to nearest so the nearest requester is written last and wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = last_grant;
    cand        = last_grant;
    for (int k = NUM_CH; k >= 1; k--) begin
      cand = last_grant + ch_idx_t'(k);
      if (req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/demux_1x4_rr_sched.sv
// Credit-based RR scheduler feeding a 1x4 demux: accept->strobe is 2 edges, in_ready low in ARB.
// Optional per-channel grant statistics under DEMUX_SCHED_STATS_EN.
module demux_1x4_rr_sched
  import demux_sched_pkg::*;
#(
  parameter int DATA_W  = 1,
  parameter int CREDITS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0] credit_ret,
  output logic [1:0]        sel,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic [NUM_CH-1:0] ch_has_credit,
  output logic              err_ovf
`ifdef DEMUX_SCHED_STATS_EN
  ,
  input  logic [1:0]        stat_idx,
  output logic [15:0]       stat_count
`endif
);

  localparam logic [3:0] CRED_MAX = 4'(CREDITS);

  sched_state_t             state_q, state_d;
  logic [DATA_W-1:0]        hold_q, hold_d;
  ch_idx_t                  sel_q, sel_d;
  logic [DATA_W-1:0]        out_data_q, out_data_d;
  logic                     out_valid_q, out_valid_d;
  ch_idx_t                  last_grant_q, last_grant_d;
  logic [NUM_CH-1:0][3:0]   cnt_q, cnt_d;
  logic                     err_ovf_q, err_ovf_d;

  logic                     accept;
  logic                     grant_valid;
  ch_idx_t                  grant_idx;
  logic [NUM_CH-1:0]        grant_oh;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      ch_has_credit[i] = (cnt_q[i] != 4'd0);
    end
  end

  assign in_ready  = (state_q != ARB);
  assign accept    = in_valid & in_ready;
  assign sel       = sel_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign err_ovf   = err_ovf_q;

  rr_arb4 u_arb (
    .req         (ch_has_credit),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_comb begin
    grant_oh = '0;
    if (state_q == ARB && grant_valid) begin
      grant_oh[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    sel_d        = sel_q;
    out_data_d   = out_data_q;
    out_valid_d  = 1'b0;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          hold_d  = in_data;
          state_d = ARB;
        end
      end
      ARB: begin
        if (grant_valid) begin
          sel_d        = grant_idx;
          out_data_d   = hold_q;
          out_valid_d  = 1'b1;
          last_grant_d = grant_idx;
          state_d      = SEND;
        end
      end
      SEND: begin
        if (accept) begin
          hold_d  = in_data;
          state_d = ARB;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A grant and a return on the same channel cancel; a return to a full counter is an overflow.
  always_comb begin
    cnt_d     = cnt_q;
    err_ovf_d = err_ovf_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant_oh[i] && !credit_ret[i]) begin
        cnt_d[i] = cnt_q[i] - 4'd1;
      end else if (!grant_oh[i] && credit_ret[i]) begin
        if (cnt_q[i] >= CRED_MAX) begin
          err_ovf_d = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      sel_q        <= 2'b00;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      last_grant_q <= 2'b11;
      cnt_q        <= {NUM_CH{CRED_MAX}};
      err_ovf_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      sel_q        <= sel_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      err_ovf_q    <= err_ovf_d;
    end
  end

`ifdef DEMUX_SCHED_STATS_EN
  logic [NUM_CH-1:0][15:0] stat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (grant_oh[i] && stat_q[i] != 16'hFFFF) begin
          stat_q[i] <= stat_q[i] + 16'd1;
        end
      end
    end
  end

  assign stat_count = stat_q[stat_idx];
`endif

endmodule

// File: tb/tb_demux_1x4_rr_sched.sv
// Directed bench for demux_1x4_rr_sched: reset, rotation, starvation, credit corner cases, mid-op reset.
module tb_demux_1x4_rr_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [3:0] credit_ret;
  logic [1:0] sel;
  logic [7:0] out_data;
  logic       out_valid;
  logic [3:0] ch_has_credit;
  logic       err_ovf;
`ifdef DEMUX_SCHED_STATS_EN
  logic [1:0]  stat_idx;
  logic [15:0] stat_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  demux_1x4_rr_sched #(.DATA_W(8), .CREDITS(4)) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .credit_ret    (credit_ret),
    .sel           (sel),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .ch_has_credit (ch_has_credit),
    .err_ovf       (err_ovf)
`ifdef DEMUX_SCHED_STATS_EN
    ,
    .stat_idx      (stat_idx),
    .stat_count    (stat_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    credit_ret = 4'b0000;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Accept one word, optionally return credits on the grant edge, then check the strobe.
  task automatic send(input logic [7:0] d, input logic [1:0] exp_sel, input logic [3:0] ret);
    chk("ready_before_accept", in_ready, 1);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid   = 1'b0;
    credit_ret = ret;
    step();
    credit_ret = 4'b0000;
    chk("grant_valid", out_valid, 1);
    chk("grant_sel", sel, exp_sel);
    chk("grant_data", out_data, d);
  endtask

  int seq_sel [17] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3, 1};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
`ifdef DEMUX_SCHED_STATS_EN
    stat_idx = 2'd2;
`endif
    // Reset values, sampled while reset is held
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    credit_ret = 4'b0000;
    step();
    chk("rst_sel", sel, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_credit", ch_has_credit, 4'b1111);
    chk("rst_err_ovf", err_ovf, 0);
    rst_n = 1'b1;
    step();

    // Single word: ARB cycle has no strobe, then one-cycle strobe to channel 0
    in_valid = 1'b1;
    in_data  = 8'h01;
    step();
    in_valid = 1'b0;
    chk("single_arb_no_valid", out_valid, 0);
    chk("single_arb_not_ready", in_ready, 0);
    step();
    chk("single_valid", out_valid, 1);
    chk("single_sel", sel, 0);
    chk("single_data", out_data, 8'h01);
    chk("single_credit", ch_has_credit, 4'b1111);
    step();
    chk("single_strobe_one_cycle", out_valid, 0);
    chk("single_idle_ready", in_ready, 1);

    // Rotation, then drain every credit
    do_reset();
    for (int i = 0; i < 8; i++) send(8'h10 + 8'(i), 2'(i % 4), 4'b0000);
    chk("rot8_credit", ch_has_credit, 4'b1111);
`ifdef DEMUX_SCHED_STATS_EN
    chk("stat_ch2", stat_count, 2);
`endif
    for (int i = 8; i < 13; i++) send(8'h10 + 8'(i), 2'(i % 4), 4'b0000);
    chk("rot13_credit", ch_has_credit, 4'b1110);
    for (int i = 13; i < 16; i++) send(8'h10 + 8'(i), 2'(i % 4), 4'b0000);
    chk("rot16_credit", ch_has_credit, 4'b0000);
    step();

    // Starvation: word held in ARB until a credit returns to channel 2
    in_valid = 1'b1;
    in_data  = 8'hA5;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    chk("starve_not_ready", in_ready, 0);
    chk("starve_no_valid", out_valid, 0);
    credit_ret = 4'b0100;
    step();
    credit_ret = 4'b0000;
    chk("starve_ret_no_valid", out_valid, 0);
    chk("starve_ret_credit", ch_has_credit, 4'b0100);
    step();
    chk("starve_valid", out_valid, 1);
    chk("starve_sel", sel, 2);
    chk("starve_data", out_data, 8'hA5);
    step();

    // Grant and return hit channel 1 together on the 10th word while its count is 2
    do_reset();
    for (int i = 0; i < 17; i++) begin
      send(8'h40 + 8'(i), 2'(seq_sel[i]), (i == 9) ? 4'b0010 : 4'b0000);
    end
    chk("simul_drained", ch_has_credit, 4'b0000);
    chk("simul_no_err", err_ovf, 0);
    step();

    // Overflow: refill a non-full counter is fine, return to a full counter is sticky error
    do_reset();
    send(8'h33, 2'd0, 4'b0000);
    step();
    credit_ret = 4'b0001;
    step();
    credit_ret = 4'b0000;
    chk("refill_no_err", err_ovf, 0);
    chk("refill_credit", ch_has_credit, 4'b1111);
    credit_ret = 4'b1000;
    step();
    credit_ret = 4'b0000;
    chk("ovf_set", err_ovf, 1);
    repeat (3) step();
    chk("ovf_sticky", err_ovf, 1);

    // Reset while a word is held in ARB
    do_reset();
    chk("ovf_cleared_by_reset", err_ovf, 0);
    send(8'h44, 2'd0, 4'b0000);
    in_valid = 1'b1;
    in_data  = 8'h55;
    step();
    in_valid = 1'b0;
    chk("midrst_in_arb", in_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", in_ready, 1);
    chk("midrst_no_valid", out_valid, 0);
    step();
    chk("midrst_held_no_valid", out_valid, 0);
    rst_n = 1'b1;
    step();
    chk("midrst_after_no_valid", out_valid, 0);
    send(8'h66, 2'd0, 4'b0000);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux_1x4_rr_sched.md
# demux_1x4_rr_sched

Credit-based round-robin scheduler that sits directly upstream of the 1x4 demultiplexer. It accepts data words over a valid/ready handshake, picks one of four output channels that still holds credit, and drives the demux `sel` and `in` together with a one-cycle `out_valid` strobe. Downstream consumers return credits per channel, so no channel is overrun.

## Interface
Parameters:
- `DATA_W`, default 1: data word width, matching the demux data input.
- `CREDITS`, default 4: initial and maximum credit count per channel, 1..15.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream word valid.
- `in_ready`  out  1  scheduler can accept a word.
- `in_data`  in  DATA_W  upstream word.
- `credit_ret`  in  4  per-channel credit-return pulse, one credit per set bit per cycle.
- `sel`  out  2  channel select to the demux; holds its value between grants.
- `out_data`  out  DATA_W  word to the demux `in`.
- `out_valid`  out  1  one-cycle strobe; `sel` and `out_data` are valid while it is high.
- `ch_has_credit`  out  4  bit i is high when channel i credit is greater than 0.
- `err_ovf`  out  1  sticky flag: a credit was returned to a full counter.

Clock is `clk`. Reset is asynchronous, active-low, on `rst_n`. There is one clock domain.

## Operation
- FSM states:
  - IDLE: `in_ready`=1. `in_valid` & `in_ready` captures `in_data` into the hold register and moves to ARB.
  - ARB: `in_ready`=0. If any channel has credit, grant it, register `sel`, `out_data` and `out_valid`=1, decrement that channel's credit, set `last_grant`, and move to SEND. With no credit anywhere, stay in ARB holding the word.
  - SEND: `out_valid` is high this cycle and `in_ready`=1. An accept moves to ARB; otherwise move to IDLE.
- Round-robin order: search `last_grant`+1, +2, +3, +4 mod 4. The first channel with credit greater than 0 wins.
- Credits:
  - Each counter is 4 bits wide and saturates at `CREDITS`.
  - If a grant and a `credit_ret` hit the same channel in the same cycle, the count is unchanged.
  - A return while the counter equals `CREDITS`, with no grant to that channel in that cycle, leaves the count unchanged and sets `err_ovf`.
  - `err_ovf` clears only on reset.
- Reset mid-operation discards the held word. No `out_valid` is produced for it.

## Timing
- Reset values:
  - `sel`=2'b00, `out_data`=0, `out_valid`=0.
  - `in_ready`=1, because the FSM resets to IDLE.
  - `ch_has_credit`=4'b1111, `err_ovf`=0.
  - All credit counters reset to `CREDITS`. `last_grant` resets to 2'b11, so the first grant goes to channel 0.
- Latency: a word accepted at edge N gives `out_valid`=1 in the cycle after edge N+1, when credit is available.
- Throughput: one word per 2 cycles with back-to-back accepts in SEND.
- `sel`, `out_data`, `out_valid` and `err_ovf` are registered outputs.
- `in_ready` and `ch_has_credit` are decoded directly from state and counters.
- `credit_ret` is sampled every cycle in every state, including ARB stalls. A credit returned during an ARB stall is usable on the next edge.

## Configuration
- Macro `DEMUX_SCHED_STATS_EN`.
- Defined: adds input `stat_idx[1:0]` and output `stat_count[15:0]`.
  - Per-channel grant counters are 16 bits, saturate at 16'hFFFF, and reset to 0.
  - `stat_count` is a combinational read of the counter for channel `stat_idx`.
- Undefined: neither port nor the counters exist. All other behaviour is identical.

## Structure
- Package `demux_sched_pkg`: the FSM state enum `sched_state_t` (IDLE, ARB, SEND), `NUM_CH`=4, and the channel index typedef `ch_idx_t` (logic [1:0]).
- One sub-module, `rr_arb4`: a combinational 4-way round-robin picker.
  - Inputs: request vector and `last_grant`.
  - Outputs: `grant_valid` and `grant_idx`.
- Credit counters, FSM, hold register and the optional stats counters live in the top module.

## Test plan
- Reset then single word: `in_data`=1 accepted at edge 1 -> `out_valid`=1 with `sel`=0, `out_data`=1 in cycle 2; `ch_has_credit` stays 4'b1111 with `CREDITS`=4, since channel 0 drops to 3.
- Rotation: 8 back-to-back words with no returns -> `sel` sequence 0,1,2,3,0,1,2,3; then all credits are 2.
- Starvation: `CREDITS`=1, send 4 words, no returns, then a 5th -> FSM holds ARB and `in_ready`=0. Pulse `credit_ret`=4'b0100 -> next `out_valid` has `sel`=2.
- Simultaneous grant and return on channel 1 while its count is 2 -> count stays 2 and `err_ovf` stays 0. Then `credit_ret`=4'b1000 with channel 3 full -> `err_ovf`=1 and stays set.
- Reset mid-operation: assert `rst_n`=0 while in ARB with a held word -> no `out_valid`; after release the first grant goes to `sel`=0.
- With `DEMUX_SCHED_STATS_EN`: after the rotation test, `stat_idx`=2 -> `stat_count`=2.
